// File: rtl/pipe_defs_pkg.sv
// Shared pipeline definitions.
// Holds the load-size encodings used by both the MEM-stage load/store
// decode and the write-back stage, the hardwired zero register index and
// the default datapath width.
package pipe_defs;

  localparam int DATA_W = 32;

  // Load size/sign select carried down the pipe as a 3-bit field.
  // Encodings 5..7 are unused and decode as a full-word load.
  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LB  = 3'd1;
  localparam logic [2:0] LOAD_LBU = 3'd2;
  localparam logic [2:0] LOAD_LH  = 3'd3;
  localparam logic [2:0] LOAD_LHU = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_load_extend.sv
// load_extend: combinational load-data extraction and extension.
// Picks a byte or halfword out of the aligned memory word (little-endian)
// and sign- or zero-extends it to DATA_W.
// Ports:
//   Dout        in  DATA_W  raw aligned word from data memory
//   offset      in  2       byte offset within the word (address[1:0])
//   load_option in  3       load size/sign select (pipe_defs LOAD_*)
//   ext_data    out DATA_W  extended load value
module load_extend
  import pipe_defs::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] Dout,
  input  logic [1:0]   offset,
  input  logic [2:0]   load_option,
  output logic [W-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = Dout[7:0];
    case (offset)
      2'd0: byte_sel = Dout[7:0];
      2'd1: byte_sel = Dout[15:8];
      2'd2: byte_sel = Dout[23:16];
      2'd3: byte_sel = Dout[31:24];
      default: byte_sel = Dout[7:0];
    endcase
  end

  // Halfword choice uses only offset[1]; an odd offset is not trapped,
  // it simply reads the halfword that contains that byte.
  assign half_sel = offset[1] ? Dout[31:16] : Dout[15:0];

  always_comb begin
    ext_data = Dout;
    case (load_option)
      LOAD_LB:  ext_data = {{(W-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: ext_data = {{(W-8){1'b0}}, byte_sel};
      LOAD_LH:  ext_data = {{(W-16){half_sel[15]}}, half_sel};
      LOAD_LHU: ext_data = {{(W-16){1'b0}}, half_sel};
      LOAD_LW:  ext_data = Dout;
      default:  ext_data = Dout;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus architectural register file.
// Selects ALU result or extended load data, writes the GPR file (r0 reads
// as zero and ignores writes), serves two combinational read ports with
// same-cycle write-through, and produces a registered commit trace and a
// retire counter.
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   WB_WriteEnable/MemtoReg       write request / load-data select
//   WB_ALUResult, WB_Dout         ALU result (low bits = byte offset), memory word
//   WB_WriteReg, WB_load_option   destination index, load size/sign
//   WB_PC                         PC of the instruction in WB
//   ID_ReadReg1/2, ID_ReadData1/2 read ports toward decode
//   commit_valid/reg/data/pc      one-cycle-late record of each retired write
//   retire_count                  retired GPR writes since reset (wraps)
module wb_regfile
  import pipe_defs::*;
#(
  parameter int DATA_W  = pipe_defs::DATA_W,
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              WB_WriteEnable,
  input  logic              WB_MemtoReg,
  input  logic [DATA_W-1:0] WB_ALUResult,
  input  logic [DATA_W-1:0] WB_Dout,
  input  logic [4:0]        WB_WriteReg,
  input  logic [2:0]        WB_load_option,
  input  logic [DATA_W-1:0] WB_PC,
  input  logic [4:0]        ID_ReadReg1,
  input  logic [4:0]        ID_ReadReg2,
  output logic [DATA_W-1:0] ID_ReadData1,
  output logic [DATA_W-1:0] ID_ReadData2,
  output logic              commit_valid,
  output logic [4:0]        commit_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [DATA_W-1:0] commit_pc,
  output logic [CNT_W-1:0]  retire_count
);

  logic [DATA_W-1:0] gpr [REG_NUM];
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wdata;
  logic              we;

  load_extend #(.W(DATA_W)) u_load_extend (
    .Dout        (WB_Dout),
    .offset      (WB_ALUResult[1:0]),
    .load_option (WB_load_option),
    .ext_data    (load_data)
  );

  assign wdata = WB_MemtoReg ? load_data : WB_ALUResult;
  // Writes to r0 vanish entirely: no state change, no commit, no count.
  assign we    = WB_WriteEnable && (WB_WriteReg != REG_ZERO);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr[i] <= '0;
      end
    end else if (we) begin
      gpr[WB_WriteReg] <= wdata;
    end
  end

  // Write-through lets decode see the value being written this cycle,
  // removing the WB->ID hazard without a stall.
  always_comb begin
    ID_ReadData1 = '0;
    if (ID_ReadReg1 != REG_ZERO) begin
      ID_ReadData1 = (we && (ID_ReadReg1 == WB_WriteReg)) ? wdata : gpr[ID_ReadReg1];
    end
  end

  always_comb begin
    ID_ReadData2 = '0;
    if (ID_ReadReg2 != REG_ZERO) begin
      ID_ReadData2 = (we && (ID_ReadReg2 == WB_WriteReg)) ? wdata : gpr[ID_ReadReg2];
    end
  end

  // Commit trace: payload holds its last value on idle cycles so a trace
  // viewer always shows the most recent retirement.
  always_ff @(posedge clock) begin
    if (reset) begin
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
      commit_pc    <= '0;
      retire_count <= '0;
    end else begin
      commit_valid <= we;
      if (we) begin
        commit_reg   <= WB_WriteReg;
        commit_data  <= wdata;
        commit_pc    <= WB_PC;
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. The counter is built
// 4 bits wide so the wrap-around can be reached in a few cycles.
module tb_wb_regfile;

  localparam int CW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        WB_WriteEnable;
  logic        WB_MemtoReg;
  logic [31:0] WB_ALUResult;
  logic [31:0] WB_Dout;
  logic [4:0]  WB_WriteReg;
  logic [2:0]  WB_load_option;
  logic [31:0] WB_PC;
  logic [4:0]  ID_ReadReg1;
  logic [4:0]  ID_ReadReg2;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic        commit_valid;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;
  logic [31:0] commit_pc;
  logic [CW-1:0] retire_count;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  wb_regfile #(.DATA_W(32), .REG_NUM(32), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .WB_WriteEnable (WB_WriteEnable),
    .WB_MemtoReg    (WB_MemtoReg),
    .WB_ALUResult   (WB_ALUResult),
    .WB_Dout        (WB_Dout),
    .WB_WriteReg    (WB_WriteReg),
    .WB_load_option (WB_load_option),
    .WB_PC          (WB_PC),
    .ID_ReadReg1    (ID_ReadReg1),
    .ID_ReadReg2    (ID_ReadReg2),
    .ID_ReadData1   (ID_ReadData1),
    .ID_ReadData2   (ID_ReadData2),
    .commit_valid   (commit_valid),
    .commit_reg     (commit_reg),
    .commit_data    (commit_data),
    .commit_pc      (commit_pc),
    .retire_count   (retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one WB transaction half a cycle before the edge, then let the
  // combinational paths settle.
  task automatic drive(input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] dout,
                       input logic [2:0] opt, input logic [31:0] pc);
    @(negedge clock);
    WB_WriteEnable = we;
    WB_MemtoReg    = m2r;
    WB_WriteReg    = rd;
    WB_ALUResult   = alu;
    WB_Dout        = dout;
    WB_load_option = opt;
    WB_PC          = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] ld_dout;
  logic [2:0]  ld_opt  [10];
  logic [1:0]  ld_off  [10];
  logic [31:0] ld_exp  [10];
  logic [CW-1:0] exp_cnt;

  initial begin
    reset = 1'b1;
    WB_WriteEnable = 1'b0; WB_MemtoReg = 1'b0; WB_ALUResult = '0; WB_Dout = '0;
    WB_WriteReg = '0; WB_load_option = '0; WB_PC = '0;
    ID_ReadReg1 = '0; ID_ReadReg2 = '0;
    exp_cnt = '0;

    // 1. Reset two cycles; every register reads zero.
    tick(); tick();
    @(negedge clock); reset = 1'b0; #1;
    for (int i = 0; i < 32; i++) begin
      ID_ReadReg1 = 5'(i);
      ID_ReadReg2 = 5'(31 - i);
      #1;
      chk($sformatf("reset_rd1_r%0d", i), ID_ReadData1, 32'h0);
      chk($sformatf("reset_rd2_r%0d", 31 - i), ID_ReadData2, 32'h0);
    end
    chk("reset_count", 32'(retire_count), 32'h0);
    chk("reset_commit_valid", 32'(commit_valid), 32'h0);
    $display("txn reset done");

    // 2. ALU write with same-cycle write-through on both ports.
    ID_ReadReg1 = 5'd5; ID_ReadReg2 = 5'd5;
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 3'd0, 32'h0000_1000);
    chk("bypass_rd1", ID_ReadData1, 32'hDEADBEEF);
    chk("bypass_rd2", ID_ReadData2, 32'hDEADBEEF);
    tick(); exp_cnt = exp_cnt + 1'b1;
    chk("alu_commit_valid", 32'(commit_valid), 32'h1);
    chk("alu_commit_reg", 32'(commit_reg), 32'd5);
    chk("alu_commit_data", commit_data, 32'hDEADBEEF);
    chk("alu_commit_pc", commit_pc, 32'h0000_1000);
    chk("alu_count", 32'(retire_count), 32'(exp_cnt));
    $display("txn write r5=deadbeef pc=00001000");

    // Idle cycle: r5 now comes from the array, commit payload holds.
    drive(1'b0, 1'b0, 5'd5, 32'h1111_1111, 32'h0, 3'd0, 32'h0000_1004);
    chk("array_rd1_r5", ID_ReadData1, 32'hDEADBEEF);
    tick();
    chk("idle_commit_valid", 32'(commit_valid), 32'h0);
    chk("idle_commit_hold", commit_data, 32'hDEADBEEF);
    chk("idle_count", 32'(retire_count), 32'(exp_cnt));

    // 3. Load extraction into r7 from 0x80FF7F01.
    ld_dout = 32'h80FF7F01;
    ld_opt[0] = 3'd1; ld_off[0] = 2'd0; ld_exp[0] = 32'h00000001;
    ld_opt[1] = 3'd1; ld_off[1] = 2'd3; ld_exp[1] = 32'hFFFFFF80;
    ld_opt[2] = 3'd2; ld_off[2] = 2'd3; ld_exp[2] = 32'h00000080;
    ld_opt[3] = 3'd3; ld_off[3] = 2'd2; ld_exp[3] = 32'hFFFF80FF;
    ld_opt[4] = 3'd4; ld_off[4] = 2'd0; ld_exp[4] = 32'h00007F01;
    ld_opt[5] = 3'd3; ld_off[5] = 2'd1; ld_exp[5] = 32'h00007F01;
    ld_opt[6] = 3'd6; ld_off[6] = 2'd1; ld_exp[6] = 32'h80FF7F01;
    ld_opt[7] = 3'd1; ld_off[7] = 2'd1; ld_exp[7] = 32'h0000007F;
    ld_opt[8] = 3'd1; ld_off[8] = 2'd2; ld_exp[8] = 32'hFFFFFFFF;
    ld_opt[9] = 3'd4; ld_off[9] = 2'd2; ld_exp[9] = 32'h000080FF;
    ID_ReadReg1 = 5'd7; ID_ReadReg2 = 5'd5;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 5'd7, {30'h0000_0100, ld_off[i]}, ld_dout, ld_opt[i], 32'h2000 + 32'(i * 4));
      chk($sformatf("load%0d_bypass", i), ID_ReadData1, ld_exp[i]);
      chk($sformatf("load%0d_other_port", i), ID_ReadData2, 32'hDEADBEEF);
      tick(); exp_cnt = exp_cnt + 1'b1;
      chk($sformatf("load%0d_commit_data", i), commit_data, ld_exp[i]);
      chk($sformatf("load%0d_commit_pc", i), commit_pc, 32'h2000 + 32'(i * 4));
      $display("txn load opt=%0d off=%0d -> %h", ld_opt[i], ld_off[i], ID_ReadData1);
    end
    // load_option must be ignored on an ALU write.
    drive(1'b1, 1'b0, 5'd7, 32'h0000_1233, ld_dout, 3'd1, 32'h3000);
    chk("alu_ignores_opt", ID_ReadData1, 32'h0000_1233);
    tick(); exp_cnt = exp_cnt + 1'b1;
    chk("count_after_loads", 32'(retire_count), 32'(exp_cnt));

    // 4. Write to r0 is dropped.
    ID_ReadReg1 = 5'd0;
    drive(1'b1, 1'b0, 5'd0, 32'h0000_1234, 32'h0, 3'd0, 32'h4000);
    chk("r0_bypass", ID_ReadData1, 32'h0);
    tick();
    chk("r0_read", ID_ReadData1, 32'h0);
    chk("r0_commit_valid", 32'(commit_valid), 32'h0);
    chk("r0_commit_pc_hold", commit_pc, 32'h3000);
    chk("r0_count", 32'(retire_count), 32'(exp_cnt));
    $display("txn write r0 dropped");

    // 5. Reset beats a simultaneous write.
    ID_ReadReg1 = 5'd9;
    drive(1'b1, 1'b0, 5'd9, 32'h55, 32'h0, 3'd0, 32'h5000);
    tick();
    drive(1'b0, 1'b0, 5'd9, 32'h0, 32'h0, 3'd0, 32'h5004);
    chk("r9_holds_55", ID_ReadData1, 32'h55);
    @(negedge clock);
    reset = 1'b1;
    WB_WriteEnable = 1'b1; WB_WriteReg = 5'd9; WB_ALUResult = 32'hAA;
    tick();
    @(negedge clock);
    reset = 1'b0; WB_WriteEnable = 1'b0;
    #1;
    exp_cnt = '0;
    chk("reset_wins_r9", ID_ReadData1, 32'h0);
    chk("reset_wins_count", 32'(retire_count), 32'h0);
    chk("reset_wins_commit_valid", 32'(commit_valid), 32'h0);
    chk("reset_wins_commit_data", commit_data, 32'h0);
    $display("txn reset with write r9=aa");

    // 6. Counter wraps modulo 2^CW.
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      drive(1'b1, 1'b0, 5'(i % 31 + 1), 32'(i), 32'h0, 3'd0, 32'h6000 + 32'(i));
      tick(); exp_cnt = exp_cnt + 1'b1;
    end
    chk("count_all_ones", 32'(retire_count), 32'(exp_cnt));
    drive(1'b1, 1'b0, 5'd31, 32'h77, 32'h0, 3'd0, 32'h7000);
    tick(); exp_cnt = exp_cnt + 1'b1;
    chk("count_wrap", 32'(retire_count), 32'(exp_cnt));
    chk("count_wrap_zero", 32'(retire_count), 32'h0);
    chk("wrap_commit_reg", 32'(commit_reg), 32'd31);
    $display("txn counter wrap count=%0d", retire_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
